// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an asynchronous FIFO. Owns the binary and Gray
// write pointers, synchronizes the read-side Gray pointer into the write
// clock domain, and derives full, almost-full, occupancy and a sticky
// overflow flag from the synchronized view of the reader.
module fifo_write_ctrl #(
  parameter int BITSIZE      = 8,
  parameter int ADDRSIZE     = 5,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [BITSIZE-1:0]  wdata_in,
  input  logic [ADDRSIZE:0]   rptr_gray,
  output logic                mem_write,
  output logic [ADDRSIZE-1:0] mem_wadrs,
  output logic [BITSIZE-1:0]  mem_wdata,
  output logic [ADDRSIZE:0]   wptr_gray,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_LVL = PW'(DEPTH - AFULL_MARGIN);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wgray_q, wgray_d;
  logic [ADDRSIZE:0] rq1_q, rq2_q;
  logic [ADDRSIZE:0] rbin_sync;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              woverflow_q, woverflow_d;
  logic              wpush;

  // Accept a push only when not full; held off entirely while reset is asserted.
  always_comb begin
    wpush     = winc & ~wfull_q & wrst_n;
    mem_write = wpush;
    mem_wadrs = wbin_q[ADDRSIZE-1:0];
    mem_wdata = wdata_in;
  end

  // Convert the synchronized read Gray pointer back to binary (prefix XOR from the MSB).
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_sync[i] = ^(rq2_q >> i);
    end
  end

  // Next pointer values and the status flags derived from the post-push pointer.
  always_comb begin
    wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, wpush};
    wgray_d        = wbin_d ^ (wbin_d >> 1);
    wfull_d        = (wgray_d == {~rq2_q[ADDRSIZE:ADDRSIZE-1], rq2_q[ADDRSIZE-2:0]});
    wlevel_d       = wbin_d - rbin_sync;
    walmost_full_d = (wlevel_d >= AFULL_LVL);
    woverflow_d    = woverflow_q | (winc & wfull_q);
  end

  // State registers, including the two-flop read-pointer synchronizer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      rq1_q          <= '0;
      rq2_q          <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      rq1_q          <= rptr_gray;
      rq2_q          <= rq1_q;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl: a pointer-count model of the FIFO
// checked every cycle, plus hand-computed expectations at key points.
module tb_fifo_write_ctrl;

  localparam int DEPTH = 32;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [7:0] wdata_in;
  logic [5:0] rptr_gray;
  int         rptr_bin;

  logic       mem_write;
  logic [4:0] mem_wadrs;
  logic [7:0] mem_wdata;
  logic [5:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [5:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int passes = 0;

  fifo_write_ctrl #(.BITSIZE(8), .ADDRSIZE(5), .AFULL_MARGIN(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata_in(wdata_in),
    .rptr_gray(rptr_gray), .mem_write(mem_write), .mem_wadrs(mem_wadrs),
    .mem_wdata(mem_wdata), .wptr_gray(wptr_gray), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  // Free-running write clock.
  always #5 wclk = ~wclk;

  function automatic logic [5:0] to_gray(input int b);
    logic [5:0] v;
    v = b[5:0];
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Drive inputs, then let one rising edge sample them; returns 2ns after that edge.
  task automatic applyStimulus(input logic inc, input logic [7:0] data, input int rb);
    winc      = inc;
    wdata_in  = data;
    rptr_bin  = rb;
    rptr_gray = to_gray(rb);
    @(posedge wclk);
    #2;
  endtask

  // Model: count of accepted pushes and reader position seen two edges late.
  int m_wptr = 0, m_level = 0, s1 = 0, s2 = 0;
  bit m_full = 0, m_ovf = 0;

  // Advance the model on each write edge; clear it on reset.
  always @(posedge wclk or negedge wrst_n) begin : mdl
    int np;
    int lv;
    if (!wrst_n) begin
      m_wptr  <= 0;
      m_level <= 0;
      m_full  <= 0;
      m_ovf   <= 0;
      s1      <= 0;
      s2      <= 0;
    end else begin
      np = (winc && !m_full) ? (m_wptr + 1) % 64 : m_wptr;
      lv = (np - s2 + 64) % 64;
      if (winc && m_full) m_ovf <= 1;
      m_wptr  <= np;
      m_level <= lv;
      m_full  <= (lv == DEPTH);
      s2      <= s1;
      s1      <= rptr_bin;
    end
  end

  // Compare every output with the model away from the active edge.
  always @(negedge wclk) begin
    checkOutput("mem_write", 32'(mem_write), 32'(wrst_n && winc && !m_full));
    checkOutput("mem_wadrs", 32'(mem_wadrs), 32'(m_wptr % 32));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(wdata_in));
    checkOutput("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wptr)));
    checkOutput("wfull", 32'(wfull), 32'(m_full));
    checkOutput("walmost_full", 32'(walmost_full), 32'((DEPTH - m_level) <= 4));
    checkOutput("wlevel", 32'(wlevel), 32'(m_level));
    checkOutput("woverflow", 32'(woverflow), 32'(m_ovf));
  end

  initial begin
    wrst_n    = 1'b0;
    winc      = 1'b1;
    wdata_in  = 8'h00;
    rptr_bin  = 0;
    rptr_gray = 6'b0;
    @(posedge wclk);
    #2;

    // Reset held with push requested.
    applyStimulus(1'b1, 8'h11, 0);
    applyStimulus(1'b1, 8'h12, 0);
    checkOutput("rst_write", 32'(mem_write), 32'd0);
    checkOutput("rst_wlevel", 32'(wlevel), 32'd0);
    checkOutput("rst_wgray", 32'(wptr_gray), 32'd0);
    checkOutput("rst_wfull", 32'(wfull), 32'd0);
    checkOutput("rst_ovf", 32'(woverflow), 32'd0);

    wrst_n = 1'b1;
    #1;
    checkOutput("rel_wadrs", 32'(mem_wadrs), 32'd0);
    checkOutput("rel_write", 32'(mem_write), 32'd1);

    // Fill with the reader parked at zero.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 8'(i), 0);
      if (i == 26) checkOutput("fill_afull27", 32'(walmost_full), 32'd0);
      if (i == 27) checkOutput("fill_afull28", 32'(walmost_full), 32'd1);
    end
    checkOutput("fill_wfull", 32'(wfull), 32'd1);
    checkOutput("fill_wlevel", 32'(wlevel), 32'd32);
    checkOutput("fill_wgray", 32'(wptr_gray), 32'b110000);

    // Push while full is dropped and latched as overflow.
    checkOutput("ovf_write", 32'(mem_write), 32'd0);
    applyStimulus(1'b1, 8'hAA, 0);
    checkOutput("ovf_flag", 32'(woverflow), 32'd1);
    checkOutput("ovf_wgray", 32'(wptr_gray), 32'b110000);
    repeat (10) applyStimulus(1'b0, 8'h00, 0);
    checkOutput("ovf_held", 32'(woverflow), 32'd1);
    checkOutput("ovf_wlevel", 32'(wlevel), 32'd32);

    // Reader advances to 4; visible only on the third edge.
    applyStimulus(1'b0, 8'h00, 4);
    checkOutput("drain_e1", 32'(wfull), 32'd1);
    applyStimulus(1'b0, 8'h00, 4);
    checkOutput("drain_e2", 32'(wfull), 32'd1);
    applyStimulus(1'b0, 8'h00, 4);
    checkOutput("drain_e3", 32'(wfull), 32'd0);
    checkOutput("drain_wlevel", 32'(wlevel), 32'd28);

    // Ten push requests, then asynchronous reset between edges.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h40 + i), 4);
    checkOutput("mid_ovf_pre", 32'(woverflow), 32'd1);
    #1;
    wrst_n    = 1'b0;
    rptr_bin  = 0;
    rptr_gray = 6'b0;
    #1;
    checkOutput("mid_wgray", 32'(wptr_gray), 32'd0);
    checkOutput("mid_wlevel", 32'(wlevel), 32'd0);
    checkOutput("mid_wfull", 32'(wfull), 32'd0);
    checkOutput("mid_ovf", 32'(woverflow), 32'd0);
    checkOutput("mid_write", 32'(mem_write), 32'd0);
    applyStimulus(1'b1, 8'h55, 0);
    wrst_n = 1'b1;
    #1;
    checkOutput("mid_rel_wadrs", 32'(mem_wadrs), 32'd0);
    checkOutput("mid_rel_write", 32'(mem_write), 32'd1);

    // Reader tracking the writer through two address wraps.
    for (int i = 0; i < 64; i++) begin
      if (i == 32) checkOutput("wrap_wadrs", 32'(mem_wadrs), 32'd0);
      applyStimulus(1'b1, 8'(i + 100), i);
      if (i % 16 == 15) checkOutput("wrap_nofull", 32'(wfull), 32'd0);
    end
    checkOutput("wrap_wgray", 32'(wptr_gray), 32'd0);
    checkOutput("wrap_ovf", 32'(woverflow), 32'd0);

    applyStimulus(1'b0, 8'h00, 63);
    applyStimulus(1'b0, 8'h00, 63);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 Parameter BITSIZE, default 8, data word width.
REQ-002 Parameter ADDRSIZE, default 5, memory address width; DEPTH = 2**ADDRSIZE = 32 entries.
REQ-003 Parameter AFULL_MARGIN, default 4, free-entry count at or below which walmost_full asserts.
REQ-004 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-005 wrst_n  input  1  reset, asynchronous, active-low.
REQ-006 winc  input  1  push request from the producer.
REQ-007 wdata_in  input  BITSIZE  push data.
REQ-008 rptr_gray  input  ADDRSIZE+1  read-side Gray pointer, asynchronous to wclk.
REQ-009 mem_write  output  1  write strobe to the dual-port memory.
REQ-010 mem_wadrs  output  ADDRSIZE  write address to the memory.
REQ-011 mem_wdata  output  BITSIZE  write data to the memory.
REQ-012 wptr_gray  output  ADDRSIZE+1  registered write Gray pointer for the read domain.
REQ-013 wfull  output  1  FIFO full, registered.
REQ-014 walmost_full  output  1  free entries <= AFULL_MARGIN, registered.
REQ-015 wlevel  output  ADDRSIZE+1  occupancy as seen from the write domain, registered, range 0..DEPTH.
REQ-016 woverflow  output  1  sticky: a push was attempted while full.

Function
REQ-017 Internal state: binary write pointer wbin (ADDRSIZE+1 bits), wptr_gray register, two-flop synchronizer rq1/rq2 on rptr_gray, wfull, walmost_full, wlevel, and woverflow registers.
REQ-018 Push accepted: wpush = winc & ~wfull, combinational; mem_write SHALL equal wpush in the same cycle.
REQ-019 mem_wadrs SHALL equal wbin[ADDRSIZE-1:0]; mem_wdata SHALL equal wdata_in; both combinational.
REQ-020 On each edge: wbin_next = wbin + wpush, modulo 2**(ADDRSIZE+1); wbin <= wbin_next; wptr_gray <= wbin_next ^ (wbin_next >> 1).
REQ-021 Synchronizer: rq1 <= rptr_gray, rq2 <= rq1 each edge; no other logic reads rq1.
REQ-022 Full: wfull <= (gray(wbin_next) == {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]}).
REQ-023 rbin_sync = Gray-to-binary of rq2 (XOR prefix from MSB), combinational.
REQ-024 wlevel <= (wbin_next - rbin_sync) modulo 2**(ADDRSIZE+1); walmost_full <= (wlevel_next >= DEPTH - AFULL_MARGIN).
REQ-025 winc while wfull = 1: push dropped, mem_write = 0, wbin unchanged, woverflow <= 1 and stays 1 until reset.
REQ-026 wfull is registered; a push SHALL be dropped in any cycle where wfull = 1, even if rq2 shows freed space that cycle.
REQ-027 A read-pointer change on rptr_gray SHALL affect wfull, walmost_full and wlevel no earlier than the third rising wclk edge after it is stable.
REQ-028 Wrap-around: mem_wadrs SHALL step 31 -> 0; wbin and wptr_gray SHALL wrap from 63 to 0 with no special handling.
REQ-029 wlevel SHALL never exceed DEPTH; wfull = 1 iff wlevel = DEPTH.

Reset
REQ-030 While wrst_n = 0: wbin, wptr_gray, rq1, rq2, wlevel = 0; wfull, walmost_full, woverflow = 0; mem_write = 0 regardless of winc.
REQ-031 Reset asserted mid-burst SHALL clear all state immediately, without waiting for wclk; the first push after release SHALL write address 0.

Verification
REQ-032 Reset: wrst_n = 0 with winc = 1 -> all outputs 0, mem_write = 0; release -> first push mem_wadrs = 0.
REQ-033 Fill: rptr_gray = 0, 32 consecutive pushes -> mem_wadrs 0..31; walmost_full = 1 after 28th push edge; wfull = 1, wlevel = 32, wptr_gray = 6'b110000 after 32nd edge.
REQ-034 Overflow: 33rd push while full -> mem_write = 0, wbin unchanged, woverflow = 1 and held through 10 further idle cycles.
REQ-035 Drain visibility: when full, set rptr_gray = 6'b000110 (binary 4) -> wfull stays 1 for two edges, clears on third edge, wlevel = 28.
REQ-036 Wrap: read pointer tracking writes, 64 total pushes -> mem_wadrs wraps 31 -> 0 twice, wptr_gray returns to 6'b000000, wfull never asserts.
REQ-037 Reset mid-operation: assert wrst_n = 0 after 10 pushes between edges -> outputs clear asynchronously; after release, pushes restart at address 0 with woverflow = 0.
